// File: rtl/otter_divider.sv
// ============================================================================
// otter_divider : RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, 35-cycle op
// Option: OTTER_DIV_FASTPATH_EN (divide-by-zero/overflow finish in 2 cycles)
// Rev 1.0
// ============================================================================
`default_nettype none

module otter_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  div_fun,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_is_rem;
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [31:0] r_rem;
    logic [31:0] r_a_raw;
    logic [4:0]  r_count;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_div_zero;
    logic        r_ovf;
    logic [31:0] r_result;

    logic        w_signed;
    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_zero;
    logic        w_ovf;
    logic        w_special;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_fix_result;

    function automatic logic [31:0] special_result(input logic is_rem,
                                                   input logic div_zero,
                                                   input logic [31:0] a);
        if (div_zero)
            special_result = is_rem ? a : 32'hFFFF_FFFF;
        else
            special_result = is_rem ? 32'h0000_0000 : 32'h8000_0000;
    endfunction

    // Operand conditioning at acceptance
    assign w_signed   = ~div_fun[0];
    assign w_sign_a   = w_signed & srcA[31];
    assign w_sign_b   = w_signed & srcB[31];
    assign w_mag_a    = w_sign_a ? (32'd0 - srcA) : srcA;
    assign w_mag_b    = w_sign_b ? (32'd0 - srcB) : srcB;
    assign w_div_zero = (srcB == 32'd0);
    assign w_ovf      = w_signed & (srcA == 32'h8000_0000) & (srcB == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero | w_ovf;

    // Partial remainder stays below the divisor, so 32 stored bits suffice;
    // only the shifted trial value needs the 33rd bit.
    assign w_shift = {r_rem, r_dvd[31]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    assign w_quot_fix   = r_sign_q ? (32'd0 - r_dvd) : r_dvd;
    assign w_rem_fix    = r_sign_r ? (32'd0 - r_rem) : r_rem;
    assign w_fix_result = (r_div_zero | r_ovf) ? special_result(r_is_rem, r_div_zero, r_a_raw)
                        : (r_is_rem ? w_rem_fix : w_quot_fix);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != IDLE);
        done        = (r_state == DONE);
        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef OTTER_DIV_FASTPATH_EN
                    w_state_nxt = w_special ? DONE : CALC;
`else
                    w_state_nxt = CALC;
`endif
                end
            end
            CALC:    if (r_count == 5'd0) w_state_nxt = FIX;
            FIX:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_rem   <= 1'b0;
            r_dvd      <= 32'd0;
            r_dvs      <= 32'd0;
            r_rem      <= 32'd0;
            r_a_raw    <= 32'd0;
            r_count    <= 5'd0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_result   <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_rem   <= div_fun[1];
                        r_dvd      <= w_mag_a;
                        r_dvs      <= w_mag_b;
                        r_rem      <= 32'd0;
                        r_a_raw    <= srcA;
                        r_count    <= 5'd31;
                        r_sign_q   <= w_sign_a ^ w_sign_b;
                        r_sign_r   <= w_sign_a;
                        r_div_zero <= w_div_zero;
                        r_ovf      <= w_ovf;
`ifdef OTTER_DIV_FASTPATH_EN
                        if (w_special)
                            r_result <= special_result(div_fun[1], w_div_zero, srcA);
`endif
                    end
                end
                CALC: begin
                    r_rem <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
                    r_dvd <= {r_dvd[30:0], ~w_trial[32]};
                    if (r_count != 5'd0)
                        r_count <= r_count - 5'd1;
                end
                FIX:     r_result <= w_fix_result;
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_otter_divider.sv
// Directed-vector bench for otter_divider: result, latency, busy occupancy,
// ignored restart, asynchronous abort and back-to-back issue.
`timescale 1ns/1ps

module tb_otter_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  div_fun = 2'b00;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] F_DIV = 2'b00, F_DIVU = 2'b01, F_REM = 2'b10, F_REMU = 2'b11;
    localparam int NORM_LAT = 34;
`ifdef OTTER_DIV_FASTPATH_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 34;
`endif

    otter_divider dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .div_fun (div_fun),
        .srcA    (srcA),
        .srcB    (srcB),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op; lat = samples from acceptance edge to done (-1 on timeout)
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_n, output logic [31:0] res);
        @(negedge clk);
        div_fun = f; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        div_fun = ~f; srcA = $urandom; srcB = $urandom;
        lat = 1; busy_n = 0;
        while (!done && lat < 100) begin
            busy_n += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        busy_n += int'(busy);
        res = result;
        if (!done) lat = -1;
    endtask

    vec_t vecs[22];

    initial begin
        int          lat, busy_n, pulses, t1, t2;
        logic [31:0] res;
        string       nm;

        vecs[0]  = '{F_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{F_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        vecs[3]  = '{F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
        vecs[4]  = '{F_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
        vecs[5]  = '{F_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
        vecs[6]  = '{F_DIV,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[7]  = '{F_REMU, 32'h1234_5678,  32'd0,          32'h1234_5678,  1'b1};
        vecs[8]  = '{F_DIVU, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[9]  = '{F_REM,  32'h1234_5678,  32'd0,          32'h1234_5678,  1'b1};
        vecs[10] = '{F_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1};
        vecs[11] = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[12] = '{F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1'b1};
        vecs[13] = '{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0};
        vecs[14] = '{F_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
        vecs[15] = '{F_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[16] = '{F_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
        vecs[17] = '{F_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0};
        vecs[18] = '{F_DIVU, 32'd5,          32'd10,         32'd0,          1'b0};
        vecs[19] = '{F_REMU, 32'd5,          32'd10,         32'd5,          1'b0};
        vecs[20] = '{F_REMU, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  1'b0};
        vecs[21] = '{F_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            run_op(vecs[i].fun, vecs[i].a, vecs[i].b, lat, busy_n, res);
            nm = $sformatf("vec%0d", i);
            check({nm, "_result"},  res, vecs[i].exp);
            check({nm, "_latency"}, lat, vecs[i].special ? SPEC_LAT : NORM_LAT);
            check({nm, "_busy"},    busy_n, vecs[i].special ? SPEC_LAT : NORM_LAT);
            @(posedge clk); #1;
            check({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
            check({nm, "_idle"},       {31'd0, busy}, 32'd0);
            check({nm, "_held"},       result, vecs[i].exp);
        end

        // Restart attempt while busy is ignored
        @(negedge clk);
        div_fun = F_DIVU; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0; res = 32'd0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) begin
                start = 1'b1; div_fun = F_REMU; srcA = 32'd1000; srcB = 32'd3;
            end
            if (c == 11) start = 1'b0;
            if (done) begin
                pulses++;
                res = result;
            end
            @(posedge clk); #1;
        end
        check("restart_pulses", pulses, 1);
        check("restart_result", res, 32'd14);

        // Asynchronous abort in cycle 15
        @(negedge clk);
        div_fun = F_DIVU; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",   {31'd0, busy}, 32'd0);
        check("abort_done",   {31'd0, done}, 32'd0);
        check("abort_result", result,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_op(F_DIVU, 32'd100, 32'd7, lat, busy_n, res);
        check("post_abort_result",  res, 32'd14);
        check("post_abort_latency", lat, NORM_LAT);

        // Back-to-back with start held high
        @(negedge clk);
        div_fun = F_DIVU; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
        t1 = -1; t2 = -1;
        for (int c = 0; c < 120 && t2 < 0; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (t1 < 0) t1 = c;
                else        t2 = c;
            end
        end
        start = 1'b0;
        check("b2b_interval", t2 - t1, 35);
        check("b2b_result",   result, 32'd333);
        repeat (40) @(posedge clk);
        #1;
        check("b2b_drain_idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
